adc_scan_ctrl: RTL
==================

Name: adc_scan_ctrl

Overview:
- Periodic scan scheduler and result averager for the 24-bit ADC interface block (sync / wreg_command / channel_choice / busy / data_o / channel / rd_en).
- Issues a stretched sync once per programmable period and drives a latched channel mode and 14-bit config word.
- Counts the expected rd_en results per scan, accumulates 2^AVG_LOG2 signed samples per channel, and presents averaged words on a valid/ready port.
- Flags overrun and timeout conditions as sticky status bits.

Parameters:
- FREQ_MHZ, 12, clk frequency in MHz.
- PERIOD_US, 1000, scan period in µs. PERIOD_CYC = FREQ_MHZ*PERIOD_US.
- SYNC_LEN, 8, sync high time in clk cycles. Must be ≥ ADC strobe period.
- AVG_LOG2, 2, log2 of samples averaged per channel (0..6).
- TIMEOUT_CYC, 65535, maximum clk cycles to wait for a scan's results.

Ports:
- clk in 1: clock.
- rst_l in 1: reset.
- enable in 1: run scans.
- mode in 2: 0/3 both channels, 1 ch1 only, 2 ch2 only.
- cfg in 14: ADC config word (without mux bits).
- adc_sync out 1: to ADC sync.
- adc_wreg_command out 14: to ADC wreg_command.
- adc_channel_choice out 2: to ADC channel_choice.
- adc_busy in 1: ADC busy.
- adc_data in 24: ADC data_o.
- adc_channel in 1: ADC channel (0 = ch1, 1 = ch2).
- adc_rd_en in 1: ADC result strobe.
- avg_data out 24: averaged sample, two's complement.
- avg_channel out 1: channel of avg_data.
- avg_valid out 1: avg_data valid.
- avg_ready in 1: consumer accept.
- clr_status in 1: clears sticky flags.
- overrun out 1: sticky flag.
- timeout out 1: sticky flag.

Behaviour:
- Reset is rst_l, asynchronous, active-low; clock is clk.
- On reset, all outputs are 0, accumulators and counters are 0, and the FSM is in IDLE.
- Period timer runs only while the FSM is not in IDLE. It counts 0..PERIOD_CYC-1 and emits a one-cycle tick on wrap. It restarts at 0 on leaving IDLE.
- Result count per scan: EXP = 2 if latched mode is 0 or 3, else EXP = 1.
- FSM states:
  - IDLE: wait for enable=1 and adc_busy=0. Then latch mode→adc_channel_choice and cfg→adc_wreg_command, and go to SYNC. The tick is not needed for the first scan.
  - SYNC: adc_sync=1 for SYNC_LEN cycles, then go to WAIT with rcnt=0 and tcnt=0.
  - WAIT: each adc_rd_en increments rcnt and feeds the accumulator. Go to ARMED when rcnt==EXP. If tcnt reaches TIMEOUT_CYC first, set timeout, discard this scan's partial contribution (restore per-channel counts from the scan start), and go to ARMED.
  - ARMED: if enable=0, go to IDLE. Otherwise, on tick, go to SYNC.
- A tick seen in SYNC or WAIT sets overrun and is dropped. No queued sync.
- enable=0 during SYNC or WAIT: the scan completes or times out, then ARMED→IDLE. Entry to IDLE clears accumulators and sample counts.
- mode and cfg changes take effect only at the next IDLE exit.
- Accumulator, per channel:
  - Width is 24+AVG_LOG2, signed. adc_data is sign-extended and added on adc_rd_en for the channel given by adc_channel.
  - After 2^AVG_LOG2 samples, result = acc >>> AVG_LOG2 (arithmetic, truncating toward −∞). The accumulator and count then clear.
- Output register:
  - When a result completes and avg_valid=0, load avg_data/avg_channel and set avg_valid=1 on the next cycle.
  - avg_valid clears on the cycle where avg_valid&&avg_ready.
  - If avg_valid=1 and the handshake is not completing in that cycle, the new result is dropped and overrun is set.
  - If the handshake completes in the same cycle a result is ready, the new result loads (no drop).
- Both channels can never complete in the same cycle, because rd_en pulses are distinct.
- clr_status=1 clears overrun and timeout. A simultaneous set wins.
- Async reset mid-scan: immediate return to IDLE, adc_sync=0, no output emitted.

Decomposition:
- Package adc_scan_pkg holds:
  - the state encoding (IDLE, SYNC, WAIT, ARMED);
  - mode constants MODE_BOTH0=0, MODE_CH1=1, MODE_CH2=2, MODE_BOTH3=3;
  - a function exp_results(mode).
- Sub-module adc_avg_acc, instantiated twice (one per channel):
  - inputs: sample, add strobe, clear, restore;
  - outputs: result and a done pulse;
  - parameterised by AVG_LOG2.

Test Plan:
- Config: PERIOD_US=100 (1200 cycles), AVG_LOG2=2, mode=0, avg_ready=1. Model returns ch1 samples 100, 200, 300, 400 and ch2 samples −4 each -> avg_data=250 ch0, then 0xFFFFFC ch1. Sync pulses are exactly 1200 cycles apart, each 8 cycles high.
- mode=1, samples −1, −2, −2, −3 -> avg_data=0xFFFFFE (−8>>>2 = −2). Exactly one rd_en is expected per scan.
- Model never asserts rd_en after sync -> after 65535 cycles timeout=1, FSM in ARMED, next sync on the following tick. clr_status clears the flag.
- avg_ready=0 while two results complete -> first result held valid, second dropped, overrun=1. avg_data unchanged.
- Model rd_en latency > PERIOD_CYC -> overrun=1, no sync during WAIT.
- enable dropped mid-WAIT, then rst_l pulsed mid-SYNC -> scan finishes then IDLE. On reset, all outputs immediately 0.

Source files
------------

// File: rtl/adc_scan_pkg.sv
// Shared types and helpers for the ADC scan scheduler.
package adc_scan_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ARMED = 2'd3
  } state_t;

  localparam logic [1:0] MODE_BOTH0 = 2'd0;
  localparam logic [1:0] MODE_CH1   = 2'd1;
  localparam logic [1:0] MODE_CH2   = 2'd2;
  localparam logic [1:0] MODE_BOTH3 = 2'd3;

  // Results the ADC returns per sync for a given channel mode.
  function automatic logic [1:0] exp_results(input logic [1:0] m);
    return (m == MODE_CH1 || m == MODE_CH2) ? 2'd1 : 2'd2;
  endfunction
endpackage

// File: rtl/adc_avg_acc.sv
// Per-channel signed accumulator: averages 2^AVG_LOG2 samples, with a
// scan-start snapshot so a timed-out scan can be rolled back.
module adc_avg_acc #(
  parameter int AVG_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic [23:0] sample,
  input  logic        add,
  input  logic        clear,
  input  logic        mark,
  input  logic        restore,
  output logic [23:0] result,
  output logic        done
);
  localparam int W  = 24 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;

  logic signed [W-1:0] acc, snap_acc, sum;
  logic [CW-1:0]       cnt, snap_cnt;

  assign sum    = acc + W'($signed(sample));
  assign done   = add && (cnt == CW'((1 << AVG_LOG2) - 1));
  assign result = 24'(sum >>> AVG_LOG2);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      acc      <= '0;
      cnt      <= '0;
      snap_acc <= '0;
      snap_cnt <= '0;
    end else if (clear) begin
      acc      <= '0;
      cnt      <= '0;
      snap_acc <= '0;
      snap_cnt <= '0;
    end else if (restore) begin
      acc <= snap_acc;
      cnt <= snap_cnt;
    end else if (done) begin
      // Completed average is already emitted; a later rollback must not revive it.
      acc      <= '0;
      cnt      <= '0;
      snap_acc <= '0;
      snap_cnt <= '0;
    end else begin
      if (mark) begin
        snap_acc <= acc;
        snap_cnt <= cnt;
      end
      if (add) begin
        acc <= sum;
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/adc_scan_ctrl.sv
// Periodic ADC scan scheduler: stretched sync per period, result counting,
// per-channel averaging, valid/ready output and sticky overrun/timeout.
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter int FREQ_MHZ    = 12,
  parameter int PERIOD_US   = 1000,
  parameter int SYNC_LEN    = 8,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [13:0] cfg,
  output logic        adc_sync,
  output logic [13:0] adc_wreg_command,
  output logic [1:0]  adc_channel_choice,
  input  logic        adc_busy,
  input  logic [23:0] adc_data,
  input  logic        adc_channel,
  input  logic        adc_rd_en,
  output logic [23:0] avg_data,
  output logic        avg_channel,
  output logic        avg_valid,
  input  logic        avg_ready,
  input  logic        clr_status,
  output logic        overrun,
  output logic        timeout
);
  localparam int PERIOD_CYC = FREQ_MHZ * PERIOD_US;
  localparam int PW = $clog2(PERIOD_CYC + 1);
  localparam int SW = $clog2(SYNC_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t         state, nxt;
  logic [PW-1:0]  pcnt;
  logic [SW-1:0]  scnt;
  logic [TW-1:0]  tcnt;
  logic [1:0]     rcnt;
  logic           tick, sync_done, rd_hit, scan_done, tmo_hit;
  logic           acc_clr, acc_mark, res_rdy, drop, ovr_set;
  logic [1:0]     add_v, done_v;
  logic [1:0][23:0] res_v;

  assign tick      = (state != ST_IDLE) && (pcnt == PW'(PERIOD_CYC - 1));
  assign sync_done = (scnt == SW'(SYNC_LEN - 1));
  assign rd_hit    = (state == ST_WAIT) && adc_rd_en;
  assign scan_done = rd_hit && ((rcnt + 2'd1) == exp_results(adc_channel_choice));
  assign tmo_hit   = (state == ST_WAIT) && !scan_done && (tcnt == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:  if (enable && !adc_busy) nxt = ST_SYNC;
      ST_SYNC:  if (sync_done) nxt = ST_WAIT;
      ST_WAIT:  if (scan_done || tmo_hit) nxt = ST_ARMED;
      ST_ARMED: if (!enable) nxt = ST_IDLE;
                else if (tick) nxt = ST_SYNC;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    adc_sync = (state == ST_SYNC);
    acc_clr  = (state == ST_IDLE);
    acc_mark = (state == ST_SYNC);
    add_v    = '0;
    if (rd_hit && !tmo_hit) add_v[adc_channel] = 1'b1;
  end

  for (genvar g = 0; g < 2; g++) begin : g_ch
    adc_avg_acc #(.AVG_LOG2(AVG_LOG2)) u_acc (
      .clk     (clk),
      .rst_l   (rst_l),
      .sample  (adc_data),
      .add     (add_v[g]),
      .clear   (acc_clr),
      .mark    (acc_mark),
      .restore (tmo_hit),
      .result  (res_v[g]),
      .done    (done_v[g])
    );
  end

  assign res_rdy = |done_v;
  assign drop    = res_rdy && avg_valid && !avg_ready;
  assign ovr_set = drop || (tick && (state == ST_SYNC || state == ST_WAIT));

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pcnt               <= '0;
      scnt               <= '0;
      tcnt               <= '0;
      rcnt               <= '0;
      adc_wreg_command   <= '0;
      adc_channel_choice <= '0;
      avg_data           <= '0;
      avg_channel        <= 1'b0;
      avg_valid          <= 1'b0;
      overrun            <= 1'b0;
      timeout            <= 1'b0;
    end else begin
      if (state == ST_IDLE && nxt == ST_SYNC) begin
        adc_channel_choice <= mode;
        adc_wreg_command   <= cfg;
      end
      pcnt <= (state == ST_IDLE || tick) ? '0 : pcnt + PW'(1);
      scnt <= (state == ST_SYNC && !sync_done) ? scnt + SW'(1) : '0;
      tcnt <= (state == ST_WAIT) ? tcnt + TW'(1) : '0;
      if (state != ST_WAIT) rcnt <= '0;
      else if (rd_hit)      rcnt <= rcnt + 2'd1;
      // A completing handshake frees the register for a same-cycle result.
      if (res_rdy && !drop) begin
        avg_valid   <= 1'b1;
        avg_data    <= done_v[1] ? res_v[1] : res_v[0];
        avg_channel <= done_v[1];
      end else if (avg_valid && avg_ready) begin
        avg_valid <= 1'b0;
      end
      if (ovr_set)         overrun <= 1'b1;
      else if (clr_status) overrun <= 1'b0;
      if (tmo_hit)         timeout <= 1'b1;
      else if (clr_status) timeout <= 1'b0;
    end
  end
endmodule
